// File: rtl/if_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage and decode-side helpers:
// the fetch FSM state type, the jump format code, the bit positions of every
// field inside a 16-bit instruction word, and the decoded field bundle.
// ----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_PRESENT,
        ST_DRAIN
    } fetch_state_t;

    localparam logic [1:0] FMT_JUMP = 2'b11;

    localparam int FMT_HI   = 15;
    localparam int FMT_LO   = 14;
    localparam int OP_HI    = 13;
    localparam int OP_LO    = 10;
    localparam int RD_HI    = 9;
    localparam int RD_LO    = 7;
    localparam int RS1_HI   = 6;
    localparam int RS1_LO   = 4;
    localparam int RS2_HI   = 3;
    localparam int RS2_LO   = 1;
    localparam int IMMF_BIT = 0;

    // imm shares its bits with reg2; immFlag tells decode which meaning applies.
    typedef struct packed {
        logic [1:0] fmt;
        logic [3:0] opcode;
        logic [2:0] regD;
        logic [2:0] reg1;
        logic [2:0] reg2;
        logic [2:0] imm;
        logic       immFlag;
    } if_fields_t;

endpackage

// File: rtl/if_fetch_stage_field_split.sv
// ----------------------------------------------------------------------------
// if_field_split
// Purely combinational splitter: one 16-bit instruction word in, the decoded
// field bundle out. Also used by decode-side checkers.
// Ports:
//   i_word   : 16-bit instruction word
//   o_fields : format/opcode/regD/reg1/reg2/imm/immFlag bundle
// ----------------------------------------------------------------------------
module if_field_split
    import if_pkg::*;
(
    input  logic [15:0] i_word,
    output if_fields_t  o_fields
);

    always_comb begin
        o_fields         = '0;
        o_fields.fmt     = i_word[FMT_HI:FMT_LO];
        o_fields.opcode  = i_word[OP_HI:OP_LO];
        o_fields.regD    = i_word[RD_HI:RD_LO];
        o_fields.reg1    = i_word[RS1_HI:RS1_LO];
        o_fields.reg2    = i_word[RS2_HI:RS2_LO];
        o_fields.imm     = i_word[RS2_HI:RS2_LO];
        o_fields.immFlag = i_word[IMMF_BIT];
    end

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, reads 16-bit
// words from instruction memory (req/rvalid, one outstanding request), fetches
// the extra target word of jump-format instructions, holds its registered
// fields under a downstream stall and discards in-flight work on a redirect.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req / imem_addr      : read request and word address (same cycle)
//   imem_rvalid / imem_rdata  : read response
//   redirect_i/redirect_pc_i  : branch taken, restart fetch at new PC
//   ready_i                   : IF/ID accepts fields this cycle
//   valid_o + field outputs   : registered instruction fields, jmpLoc_o
// ----------------------------------------------------------------------------
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [1:0]        format_o,
    output logic [3:0]        opcode_o,
    output logic [2:0]        regD_o,
    output logic [2:0]        reg1_o,
    output logic [2:0]        reg2_o,
    output logic [2:0]        imm_o,
    output logic              immFlag_o,
    output logic [15:0]       jmpLoc_o
);

    fetch_state_t      r_state;
    fetch_state_t      w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [15:0]       r_jmp;
    logic [15:0]       r_jmpLoc;
    logic              r_valid;
    if_fields_t        r_fields;
    if_fields_t        w_fields;

    logic w_req;
    logic w_irLoad;
    logic w_jmpLoad;
    logic w_jmpClear;
    logic w_pcInc;
    logic w_present;

    if_field_split u_split (
        .i_word   (r_ir),
        .o_fields (w_fields)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_irLoad    = 1'b0;
        w_jmpLoad   = 1'b0;
        w_jmpClear  = 1'b0;
        w_pcInc     = 1'b0;
        w_present   = 1'b0;

        case (r_state)
            ST_ISSUE: begin
                w_req       = 1'b1;
                w_nextState = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (imem_rvalid) begin
                    w_irLoad = 1'b1;
                    w_pcInc  = 1'b1;
                    if (imem_rdata[FMT_HI:FMT_LO] == FMT_JUMP) begin
                        w_nextState = ST_ISSUE1;
                    end else begin
                        w_jmpClear  = 1'b1;
                        w_nextState = ST_PRESENT;
                    end
                end
            end
            ST_ISSUE1: begin
                w_req       = 1'b1;
                w_nextState = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (imem_rvalid) begin
                    w_jmpLoad   = 1'b1;
                    w_pcInc     = 1'b1;
                    w_nextState = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (!r_valid || ready_i) begin
                    w_present   = 1'b1;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    w_nextState = ST_ISSUE;
                end
            end
            default: w_nextState = ST_ISSUE;
        endcase

        // A redirect cancels every update of this cycle. A response arriving in
        // the same cycle is consumed (and dropped) here, so only a request still
        // in flight after this edge needs the DRAIN state to swallow it.
        if (redirect_i) begin
            w_req      = 1'b0;
            w_irLoad   = 1'b0;
            w_jmpLoad  = 1'b0;
            w_jmpClear = 1'b0;
            w_pcInc    = 1'b0;
            w_present  = 1'b0;
            if ((r_state == ST_WAIT0 || r_state == ST_WAIT1 || r_state == ST_DRAIN)
                && !imem_rvalid) begin
                w_nextState = ST_DRAIN;
            end else begin
                w_nextState = ST_ISSUE;
            end
        end

        if (rst) begin
            w_req = 1'b0;
        end
    end

    // PC wraps modulo 2^ADDR_W; a jump at the last address fetches its target
    // from address 0 without any special handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_jmp    <= '0;
            r_jmpLoc <= '0;
            r_valid  <= 1'b0;
            r_fields <= '0;
        end else if (redirect_i) begin
            r_pc    <= redirect_pc_i;
            r_valid <= 1'b0;
        end else begin
            if (w_pcInc) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (w_irLoad) begin
                r_ir <= imem_rdata;
            end
            if (w_jmpLoad) begin
                r_jmp <= imem_rdata;
            end else if (w_jmpClear) begin
                r_jmp <= '0;
            end
            if (w_present) begin
                r_fields <= w_fields;
                r_jmpLoc <= r_jmp;
                r_valid  <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign valid_o   = r_valid;
    assign format_o  = r_fields.fmt;
    assign opcode_o  = r_fields.opcode;
    assign regD_o    = r_fields.regD;
    assign reg1_o    = r_fields.reg1;
    assign reg2_o    = r_fields.reg2;
    assign imm_o     = r_fields.imm;
    assign immFlag_o = r_fields.immFlag;
    assign jmpLoc_o  = r_jmpLoc;

endmodule
